avalon_st_packetizer: RTL

// - Transmit side of the Avalon-ST packet path. Takes a byte-length command plus a

---
 rtl/avalon_st_packetizer_if.sv | 16 +
 rtl/avalon_st_packetizer.sv | 78 +++++++
 2 files changed

// File: rtl/avalon_st_packetizer_if.sv
// Avalon-ST streaming interface: data/valid/sop/eop/empty from master, rdy from slave.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
) ();
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             sop;
  logic                             eop;
  logic [EMPTY_W-1:0]               empty;
  logic                             rdy;

  modport master (output data, output valid, output sop, output eop, output empty, input rdy);
  modport slave  (input data, input valid, input sop, input eop, input empty, output rdy);
endinterface

// File: rtl/avalon_st_packetizer.sv
// Frames a flat payload word stream into Avalon-ST packets from a byte-length command.
// Zero-latency pass-through datapath; framing comes from a remaining-bytes counter.
module avalon_st_packetizer #(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int LEN_W               = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             len_valid,
  input  logic [LEN_W-1:0]                 len_bytes,
  output logic                             len_rdy,
  input  logic                             data_in_valid,
  input  logic [8*DATA_WIDTH_IN_BYTES-1:0] data_in,
  output logic                             data_in_rdy,
  avalon_st_if.master                      msg_out,
  output logic                             len_zero_err,
  output logic                             busy
);
  localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;
  localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(DATA_WIDTH_IN_BYTES);

  logic [0:0]       r_state;
  logic [LEN_W-1:0] r_remaining;
  logic             r_first;
  logic             r_len_zero_err;

  logic             w_send;
  logic             w_eop;
  logic             w_beat;
  logic             w_cmd_accept;
  logic [LEN_W-1:0] w_empty_full;

  assign w_send       = (r_state == ST_SEND);
  assign w_eop        = (r_remaining <= BEAT_BYTES);
  assign w_empty_full = w_eop ? (BEAT_BYTES - r_remaining) : '0;
  assign w_beat       = w_send & data_in_valid & msg_out.rdy;
  assign w_cmd_accept = ~w_send & len_valid;

  assign len_rdy      = ~w_send;
  assign busy         = w_send;
  assign len_zero_err = r_len_zero_err;
  assign data_in_rdy  = w_send & msg_out.rdy;

  // Outside SEND the bus is forced quiet so an idle link never shows stale framing.
  assign msg_out.valid = w_send & data_in_valid;
  assign msg_out.data  = w_send ? data_in : '0;
  assign msg_out.sop   = w_send & r_first;
  assign msg_out.eop   = w_send & w_eop;
  assign msg_out.empty = w_send ? w_empty_full[EMPTY_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_remaining    <= '0;
      r_first        <= 1'b1;
      r_len_zero_err <= 1'b0;
    end else begin
      r_len_zero_err <= w_cmd_accept && (len_bytes == '0);
      if (w_cmd_accept && (len_bytes != '0)) begin
        r_state     <= ST_SEND;
        r_remaining <= len_bytes;
        r_first     <= 1'b1;
      end
      // eop fires at remaining<=beat width, so the subtraction never underflows.
      if (w_beat) begin
        r_first <= 1'b0;
        if (w_eop) begin
          r_state     <= ST_IDLE;
          r_remaining <= '0;
        end else begin
          r_remaining <= r_remaining - BEAT_BYTES;
        end
      end
    end
  end
endmodule
